// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
// Bundles the instruction-cache, data-cache and memory-bridge signals of the
// cache/memory arbiter.
//   slave  : arbiter view (cache requests and memory responses in,
//            cache responses and memory request out)
//   master : environment view (caches plus memory bridge), the mirror of slave
// Signal names follow the existing *_cache_req / *_cache_dok / mem_* bus.
interface cache_mem_arbiter_if;
    // Instruction cache side
    logic        inst_cache_req;
    logic [31:0] inst_cache_addr;
    logic [31:0] inst_cache_rdata;
    logic        inst_cache_dok;
    // Data cache side
    logic        data_cache_req;
    logic [31:0] data_cache_addr;
    logic [3:0]  data_cache_wen;
    logic [31:0] data_cache_wdata;
    logic [31:0] data_cache_rdata;
    logic        data_cache_dok;
    // Memory bridge side
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_cache_req, inst_cache_addr,
        input  data_cache_req, data_cache_addr, data_cache_wen, data_cache_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_cache_rdata, inst_cache_dok,
        output data_cache_rdata, data_cache_dok,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output inst_cache_req, inst_cache_addr,
        output data_cache_req, data_cache_addr, data_cache_wen, data_cache_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_cache_rdata, inst_cache_dok,
        input  data_cache_rdata, data_cache_dok,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one SRAM-style memory port between the instruction and data caches.
// One transaction at a time: IDLE picks an owner and latches its fields,
// ADDR holds mem_req until mem_addr_ok, DATA waits for mem_data_ok and
// captures read data, DONE pulses the owner's dok for one cycle.
// Ports:
//   clk     : clock
//   resetn  : synchronous active-low reset
//   bus_io  : cache_mem_arbiter_if.slave (both cache ports + memory bridge)
// Parameters:
//   STARVE_LIMIT : consecutive data grants tolerated while an instruction
//                  request waits (1..15), used only with fairness enabled.
// Optional feature: define ARB_FAIRNESS_EN to build the starvation counter;
// otherwise data strictly wins over instruction.
// All outputs are registered.
module cache_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                  clk,
    input logic                  resetn,
    cache_mem_arbiter_if.slave   bus_io
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e      state_q, state_d;
    logic        owner_inst_q, owner_inst_d;   // 1: instruction port owns the bus
    logic        mem_req_q, mem_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_dok_q, inst_dok_d;
    logic        data_dok_q, data_dok_d;
    logic        grant_inst;
`ifdef ARB_FAIRNESS_EN
    logic [3:0]  starve_q, starve_d;
`endif

    always_comb begin
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_dok_d   = 1'b0;
        data_dok_d   = 1'b0;
        grant_inst   = 1'b0;
`ifdef ARB_FAIRNESS_EN
        starve_d     = starve_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus_io.inst_cache_req || bus_io.data_cache_req) begin
`ifdef ARB_FAIRNESS_EN
                    // Instruction wins once data has been granted STARVE_LIMIT
                    // times in a row over a waiting instruction request.
                    grant_inst = !bus_io.data_cache_req ||
                                 (bus_io.inst_cache_req && (starve_q == 4'(STARVE_LIMIT)));
                    if (grant_inst) begin
                        starve_d = '0;
                    end else if (bus_io.inst_cache_req) begin
                        starve_d = starve_q + 4'd1;
                    end
`else
                    grant_inst = !bus_io.data_cache_req;
`endif
                    owner_inst_d = grant_inst;
                    if (grant_inst) begin
                        mem_addr_d  = bus_io.inst_cache_addr;
                        mem_wstrb_d = 4'b0000;
                        mem_wdata_d = 32'h0;
                        mem_wr_d    = 1'b0;
                    end else begin
                        mem_addr_d  = bus_io.data_cache_addr;
                        mem_wstrb_d = bus_io.data_cache_wen;
                        mem_wdata_d = bus_io.data_cache_wdata;
                        mem_wr_d    = |bus_io.data_cache_wen;
                    end
                    mem_req_d = 1'b1;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (bus_io.mem_addr_ok) begin
                    mem_req_d = 1'b0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bus_io.mem_data_ok) begin
                    if (owner_inst_q) begin
                        inst_rdata_d = bus_io.mem_rdata;
                        inst_dok_d   = 1'b1;
                    end else begin
                        // Writes complete without touching the read data register.
                        if (!mem_wr_q) begin
                            data_rdata_d = bus_io.mem_rdata;
                        end
                        data_dok_d = 1'b1;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            owner_inst_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wstrb_q  <= 4'b0000;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            inst_dok_q   <= 1'b0;
            data_dok_q   <= 1'b0;
`ifdef ARB_FAIRNESS_EN
            starve_q     <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_dok_q   <= inst_dok_d;
            data_dok_q   <= data_dok_d;
`ifdef ARB_FAIRNESS_EN
            starve_q     <= starve_d;
`endif
        end
    end

    assign bus_io.mem_req          = mem_req_q;
    assign bus_io.mem_wr           = mem_wr_q;
    assign bus_io.mem_wstrb        = mem_wstrb_q;
    assign bus_io.mem_addr         = mem_addr_q;
    assign bus_io.mem_wdata        = mem_wdata_q;
    assign bus_io.inst_cache_rdata = inst_rdata_q;
    assign bus_io.inst_cache_dok   = inst_dok_q;
    assign bus_io.data_cache_rdata = data_rdata_q;
    assign bus_io.data_cache_dok   = data_dok_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Self-checking bench for cache_mem_arbiter. Two cache agents and a memory
// responder drive the interface; expected read data is queued per port at
// issue time, and a negedge monitor checks grants, memory fields and dok
// responses against a reference of the arbitration rules.
// Honours ARB_FAIRNESS_EN the same way as the design.
module tb_cache_mem_arbiter;
    localparam int unsigned LIMIT = 4;
    localparam int TIMEOUT = 300;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus();

    cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_io (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int dok_due = -1;          // cycle in which a dok must appear
    int aw = 0;                // directed addr_ok wait cycles
    int dw = 0;                // directed data_ok wait cycles
    bit mem_rand = 1'b0;       // random waits and spurious handshakes
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    bit          own_q[$];     // 1 = instruction owner, in grant order
    logic [31:0] d_rdata_m = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents as seen by the bench: fixed per address.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'h2408_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no dok within %0d cycles (cycle %0d)", name, TIMEOUT, cyc);
    endtask

    // Instruction agent: raise req at the next edge, hold until dok.
    task automatic inst_issue(input logic [31:0] a, output int lat);
        int n;
        int start;
        @(posedge clk); #1;
        bus.inst_cache_req  = 1'b1;
        bus.inst_cache_addr = a;
        exp_i_q.push_back(rd_fn(a));
        start = cyc;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.inst_cache_dok && n < TIMEOUT);
        if (!bus.inst_cache_dok) timeout_fail("inst_timeout");
        lat = cyc - start;
    endtask

    task automatic inst_drop();
        @(posedge clk); #1;
        bus.inst_cache_req  = 1'b0;
        bus.inst_cache_addr = $urandom();
    endtask

    task automatic data_issue(input logic [31:0] a, input logic [3:0] wen,
                              input logic [31:0] wd, output int lat);
        int n;
        int start;
        @(posedge clk); #1;
        bus.data_cache_req   = 1'b1;
        bus.data_cache_addr  = a;
        bus.data_cache_wen   = wen;
        bus.data_cache_wdata = wd;
        if (wen == 4'b0000) d_rdata_m = rd_fn(a);
        exp_d_q.push_back(d_rdata_m);
        start = cyc;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.data_cache_dok && n < TIMEOUT);
        if (!bus.data_cache_dok) timeout_fail("data_timeout");
        lat = cyc - start;
    endtask

    task automatic data_drop();
        @(posedge clk); #1;
        bus.data_cache_req   = 1'b0;
        bus.data_cache_addr  = $urandom();
        bus.data_cache_wen   = 4'($urandom());
        bus.data_cache_wdata = $urandom();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_inst_dok"}, 32'(bus.inst_cache_dok), 32'd0);
        chk({tag, "_data_dok"}, 32'(bus.data_cache_dok), 32'd0);
        chk({tag, "_inst_rdata"}, bus.inst_cache_rdata, 32'h0);
        chk({tag, "_data_rdata"}, bus.data_cache_rdata, 32'h0);
    endtask

    // Memory bridge model: addr_ok after aw waits, data_ok dw cycles later.
    initial begin : mem_model
        int ph;
        int wc;
        ph = 0;
        wc = 0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.mem_addr_ok = 1'b0;
            bus.mem_data_ok = 1'b0;
            if (mem_rand) bus.mem_rdata = $urandom();
            if (!resetn) begin
                ph = 0;
            end else begin
                if (ph == 0 && bus.mem_req) begin
                    ph = 1;
                    wc = mem_rand ? int'($urandom_range(0, 3)) : aw;
                end
                if (ph == 1) begin
                    if (wc == 0) begin
                        bus.mem_addr_ok = 1'b1;
                        ph = 2;
                        wc = mem_rand ? int'($urandom_range(0, 3)) : dw;
                    end else begin
                        wc--;
                        if (mem_rand) bus.mem_data_ok = 1'($urandom_range(0, 1));
                    end
                end else if (ph == 2) begin
                    if (wc == 0) begin
                        bus.mem_data_ok = 1'b1;
                        bus.mem_rdata   = rd_fn(bus.mem_addr);
                        ph = 0;
                        dok_due = cyc + 1;
                    end else begin
                        wc--;
                        if (mem_rand) bus.mem_addr_ok = 1'($urandom_range(0, 1));
                    end
                end else if (mem_rand) begin
                    bus.mem_addr_ok = 1'($urandom_range(0, 1));
                    bus.mem_data_ok = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: grant decisions, memory fields and dok responses.
    initial begin : monitor
        logic        pi;
        logic        pd;
        logic        pmr;
        logic        eo;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  es;
        bit          o;
        logic [31:0] e;
`ifdef ARB_FAIRNESS_EN
        int          passed_over;  // data grants in a row over a waiting inst
        passed_over = 0;
`endif
        pi = 1'b0; pd = 1'b0; pmr = 1'b0; eo = 1'b0;
        ea = '0; ewd = '0; es = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pi = 1'b0; pd = 1'b0; pmr = 1'b0;
                own_q.delete();
                dok_due = -1;
`ifdef ARB_FAIRNESS_EN
                passed_over = 0;
`endif
                continue;
            end
            if (bus.inst_cache_dok || bus.data_cache_dok) begin
                chk("dok_cycle", 32'(cyc), 32'(dok_due));
                chk("dok_onehot", 32'(bus.inst_cache_dok & bus.data_cache_dok), 32'd0);
                if (own_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dok_spurious: got dok with no grant outstanding (cycle %0d)",
                             cyc);
                end else begin
                    o = own_q.pop_front();
                    chk("dok_owner", 32'(bus.inst_cache_dok), 32'(o));
                end
                if (bus.inst_cache_dok) begin
                    if (exp_i_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL inst_dok_unexpected: got dok, expected none (cycle %0d)",
                                 cyc);
                    end else begin
                        e = exp_i_q.pop_front();
                        chk("inst_rdata", bus.inst_cache_rdata, e);
                    end
                end else begin
                    if (exp_d_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL data_dok_unexpected: got dok, expected none (cycle %0d)",
                                 cyc);
                    end else begin
                        e = exp_d_q.pop_front();
                        chk("data_rdata", bus.data_cache_rdata, e);
                    end
                end
            end else if (cyc == dok_due) begin
                tests++; fails++;
                $display("FAIL dok_missing: got no dok, expected one (cycle %0d)", cyc);
            end
            if (bus.mem_req && !pmr) begin
                chk("grant_has_req", 32'(pi | pd), 32'd1);
`ifdef ARB_FAIRNESS_EN
                eo = pi && (!pd || passed_over == int'(LIMIT));
                if (eo) passed_over = 0;
                else if (pi) passed_over++;
`else
                eo = !pd;
`endif
                if (eo) begin
                    ea = bus.inst_cache_addr; es = 4'b0000; ewd = 32'h0;
                end else begin
                    ea = bus.data_cache_addr; es = bus.data_cache_wen;
                    ewd = bus.data_cache_wdata;
                end
                own_q.push_back(eo);
            end
            if (bus.mem_req) begin
                chk("mem_addr", bus.mem_addr, ea);
                chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(es));
                chk("mem_wdata", bus.mem_wdata, ewd);
                chk("mem_wr", 32'(bus.mem_wr), 32'(|es));
            end
            pmr = bus.mem_req;
            pi  = bus.inst_cache_req;
            pd  = bus.data_cache_req;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int l1;
        int l2;
        int n;
        bus.inst_cache_req   = 1'b0;
        bus.inst_cache_addr  = 32'h0;
        bus.data_cache_req   = 1'b0;
        bus.data_cache_addr  = 32'h0;
        bus.data_cache_wen   = 4'b0000;
        bus.data_cache_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        resetn = 1'b1;

        // Single instruction read, zero-wait memory.
        aw = 0; dw = 0;
        inst_issue(32'h1FC0_0000, l1);
        chk("inst_zero_wait_lat", 32'(l1), 32'd3);
        inst_drop();

        // Data write with delayed handshakes.
        aw = 2; dw = 3;
        data_issue(32'h8000_0010, 4'b0011, 32'hDEAD_BEEF, l1);
        chk("data_write_lat", 32'(l1), 32'd8);
        data_drop();

        // Simultaneous requests: data first, inst at the next IDLE.
        aw = 0; dw = 0;
        fork
            begin data_issue(32'h0000_1000, 4'b0000, 32'h0, l1); data_drop(); end
            begin inst_issue(32'h1FC0_0004, l2); inst_drop(); end
        join
        chk("both_data_lat", 32'(l1), 32'd3);
        chk("both_inst_gap", 32'(l2 - l1), 32'd4);

        // Write-back followed by a load on the same held request.
        data_issue(32'h0000_2000, 4'b1111, 32'hCAFE_F00D, l1);
        data_issue(32'h0000_3004, 4'b0000, 32'h0, l2);
        chk("load_after_wb_lat", 32'(l2), 32'd3);
        data_drop();

        // Continuous contention.
        fork
            begin
                for (int i = 0; i < 10; i++) data_issue(32'h4000_0000 + 32'(i * 4), 4'b0000, 32'h0, l1);
                data_drop();
            end
            begin
                inst_issue(32'h1FC0_0100, l2);
                inst_issue(32'h1FC0_0104, l2);
                inst_drop();
            end
        join

        // Reset while the transaction sits in DATA.
        aw = 0; dw = 6;
        @(posedge clk); #1;
        bus.inst_cache_req  = 1'b1;
        bus.inst_cache_addr = 32'h1FC0_0200;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.mem_req && n < 20);
        @(posedge clk); #1;
        resetn = 1'b0;
        bus.inst_cache_req = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("mid_rst");
        exp_i_q.delete();
        exp_d_q.delete();
        d_rdata_m = 32'h0;
        @(posedge clk); #1;
        resetn = 1'b1;
        aw = 0; dw = 0;
        inst_issue(32'h1FC0_0300, l1);
        chk("after_reset_lat", 32'(l1), 32'd3);
        inst_drop();

        // Randomized traffic with random waits and spurious handshakes.
        mem_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int g;
                    inst_issue($urandom() & 32'hFFFF_FFFC, l1);
                    g = int'($urandom_range(0, 3));
                    if (g != 0 || i == 39) begin
                        inst_drop();
                        repeat (g) @(posedge clk);
                    end
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int g;
                    logic [3:0] w;
                    w = $urandom_range(0, 1) != 0 ? 4'($urandom()) : 4'b0000;
                    data_issue($urandom() & 32'hFFFF_FFFC, w, $urandom(), l2);
                    g = int'($urandom_range(0, 3));
                    if (g != 0 || i == 39) begin
                        data_drop();
                        repeat (g) @(posedge clk);
                    end
                end
            end
        join
        mem_rand = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("end_grants_drained", 32'(own_q.size()), 32'd0);
        chk("end_inst_drained", 32'(exp_i_q.size()), 32'd0);
        chk("end_data_drained", 32'(exp_d_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single memory port between the instruction cache and the data cache. Each cache raises a request and holds it until a one-cycle done pulse. The arbiter picks one requester and latches its address, write enable and write data. It then runs one SRAM-style address/data handshake on the memory side and returns read data to the winner. It sits between the two caches and the memory bridge; both caches see it as their `*_cache_req` / `*_cache_dok` interface.

## Interface
Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while the instruction request is pending (used only with ARB_FAIRNESS_EN); legal 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_cache_req  in  1  instruction read request, held until dok
- inst_cache_addr  in  32  instruction read address
- inst_cache_rdata  out  32  instruction read data, valid in the dok cycle and held after it
- inst_cache_dok  out  1  one-cycle completion pulse
- data_cache_req  in  1  data request, held until dok
- data_cache_addr  in  32  data address
- data_cache_wen  in  4  byte write enables; 0 = read
- data_cache_wdata  in  32  write data
- data_cache_rdata  out  32  data read data, valid in the dok cycle and held after it
- data_cache_dok  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_addr_ok
- mem_wr  out  1  1 = write (the OR of the latched wen)
- mem_wstrb  out  4  latched wen
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched write data
- mem_addr_ok  in  1  address accepted
- mem_data_ok  in  1  read data valid or write complete
- mem_rdata  in  32  read data

## Operation
States: IDLE, ADDR, DATA, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: choose the owner, latch the owner's addr/wen/wdata (inst: wen=0, wdata=0), go to ADDR.
  - Default priority is data over instruction.
- **ADDR**
  - mem_req=1 with the latched fields.
  - On mem_addr_ok: go to DATA.
- **DATA**
  - mem_req=0. Wait for mem_data_ok.
  - On mem_data_ok: capture mem_rdata into the owner's rdata register (writes leave rdata unchanged) and go to DONE.
- **DONE**
  - Owner's dok=1 for exactly this cycle, then go to IDLE.
  - Requests are ignored in DONE; a requester must drop or change its req at the edge ending its dok cycle.
  - A request still high in IDLE is a new transaction.
- Input changes while owned: latched fields stay fixed from grant to DONE; the owner's req/addr changes in that window are ignored. The non-owner's req is only sampled in IDLE.
- mem_addr_ok outside ADDR and mem_data_ok outside DATA are ignored.
- Only one transaction is outstanding at a time; there is no pipelining.

## Timing
- All outputs are registered.
- Reset values: state IDLE, mem_req 0, mem_wr 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, both dok 0, both rdata 0, starve counter 0.
- Reset mid-transaction: the transaction is abandoned. The memory bridge is reset by the same resetn.
- Zero-wait memory (addr_ok in the first mem_req cycle, data_ok the next cycle):
  - req sampled at T0
  - mem_req high at T1
  - data_ok at T2
  - dok at T3
  - earliest next grant sampled at T4
- Minimum request-to-dok latency is 3 cycles. Each extra wait cycle on addr_ok or data_ok adds one cycle.
- Back-to-back from one requester: IDLE to IDLE spacing is at least 4 cycles.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A 4-bit starve counter increments on each data grant made while inst_cache_req=1. It clears on any instruction grant.
  - When the counter equals STARVE_LIMIT and both requests are high in IDLE, the instruction port is granted and the counter clears.
- ARB_FAIRNESS_EN undefined: strict data priority. The counter is not built, and the instruction port can starve indefinitely.

## Test plan
- Single inst read, zero-wait memory, addr 0x1FC0_0000, rdata 0x2408_0001 -> mem_req at T1 with mem_wr=0; inst_cache_dok one cycle at T3 with rdata 0x2408_0001; data_cache_dok stays 0.
- Data write addr 0x8000_0010, wen 4'b0011, wdata 0xDEAD_BEEF, addr_ok delayed 2 cycles, data_ok delayed 3 cycles:
  - mem_wr=1, mem_wstrb=0011, mem_addr/mem_wdata held throughout the handshake
  - data_cache_dok 1 cycle
  - data_cache_rdata unchanged
- Both requests high at the same IDLE cycle -> data granted first. Inst is granted at the next IDLE if its req is still high. Inst dok is 4 cycles after data dok on zero-wait memory.
- Write-back then load (data req stays high across dok with a new addr) -> two separate memory transactions; the second latches the new addr; no lost or duplicated dok.
- With ARB_FAIRNESS_EN, STARVE_LIMIT=4, both requests held high continuously -> grant order D,D,D,D,I,D,D,D,D,I. Without the macro -> all grants D.
- resetn low during DATA -> next cycle: all outputs at reset values, state IDLE, no dok. A request after reset completes normally.
